// File: rtl/csi_rx_byte_align.sv
// Per-lane HS byte aligner: hunts SYNC_BYTE at 8 bit offsets, locks, emits realigned bytes until packet_done.
// Latency: 2 byte_clock edges from the edge that completes a byte; no backpressure, output is a valid strobe.
module csi_rx_byte_align #(
    parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
    input  logic       byte_clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic [7:0] deser_in,
    input  logic       wait_for_sync,
    input  logic       packet_done,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       locked,
    output logic [2:0] offset
);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  d0_q, d1_q;
    logic [7:0]  data_out_q, data_out_d;
    logic        valid_q, valid_d;
    logic        locked_q, locked_d;
    logic [2:0]  offset_q, offset_d;

    logic [15:0] window;
    logic        match;
    logic [2:0]  k_hit;
    logic [7:0]  aligned;

    // Older byte sits in the low half so bit 0 of the window is the earliest bit.
    assign window  = {d0_q, d1_q};
    assign aligned = window[offset_q +: 8];

    // Scan from the top down so the lowest matching offset wins.
    always_comb begin
        match = 1'b0;
        k_hit = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (window[k +: 8] == SYNC_BYTE) begin
                match = 1'b1;
                k_hit = k[2:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        locked_d   = 1'b0;
        offset_d   = offset_q;
        if (enable) begin
            case (state_q)
                ST_HUNT: begin
                    if (wait_for_sync && match) begin
                        state_d  = ST_LOCKED;
                        offset_d = k_hit;
                        locked_d = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (packet_done) begin
                        state_d = ST_HUNT;
                    end else begin
                        data_out_d = aligned;
                        valid_d    = 1'b1;
                        locked_d   = 1'b1;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end else begin
            state_d = ST_HUNT;
        end
    end

    always_ff @(posedge byte_clock or negedge reset_n) begin
        if (!reset_n) begin
            d0_q       <= 8'h00;
            d1_q       <= 8'h00;
            state_q    <= ST_HUNT;
            data_out_q <= 8'h00;
            valid_q    <= 1'b0;
            locked_q   <= 1'b0;
            offset_q   <= 3'd0;
        end else begin
            d0_q       <= deser_in;
            d1_q       <= d0_q;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            locked_q   <= locked_d;
            offset_q   <= offset_d;
        end
    end

    assign data_out = data_out_q;
    assign valid    = valid_q;
    assign locked   = locked_q;
    assign offset   = offset_q;

endmodule

// File: tb/tb_csi_rx_byte_align.sv
// Directed bench for csi_rx_byte_align: sync hunt, offsets, gating, packet end, enable drop, async reset.
module tb_csi_rx_byte_align;

    logic       byte_clock = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] deser_in;
    logic       wait_for_sync;
    logic       packet_done;
    logic [7:0] data_out;
    logic       valid;
    logic       locked;
    logic [2:0] offset;

    csi_rx_byte_align #(.SYNC_BYTE(8'hB8)) dut (
        .byte_clock   (byte_clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .deser_in     (deser_in),
        .wait_for_sync(wait_for_sync),
        .packet_done  (packet_done),
        .data_out     (data_out),
        .valid        (valid),
        .locked       (locked),
        .offset       (offset)
    );

    always #5 byte_clock = ~byte_clock;

    int n_checks = 0;
    int n_err    = 0;

    // Bench-side copy of the two-byte pipe, built from the bytes driven.
    logic [7:0]  h0 = 8'h00;
    logic [7:0]  h1 = 8'h00;
    logic [15:0] pre_w;
    logic [7:0]  exp_hold;
    logic [7:0]  gate_seq [6];
    logic [7:0]  sh_seq [5];
    logic [7:0]  r5_seq [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // pre_w is the window the DUT sees at the edge this call drives.
    task automatic tick(input logic [7:0] din);
        deser_in = din;
        pre_w    = {h0, h1};
        @(posedge byte_clock);
        #1;
        h1 = h0;
        h0 = din;
    endtask

    task automatic end_packet();
        packet_done = 1'b1;
        tick(8'h00);
        packet_done = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        wait_for_sync = 1'b0;
        packet_done   = 1'b0;
        deser_in      = 8'h00;
        gate_seq      = '{8'h00, 8'hB8, 8'h12, 8'h34, 8'h56, 8'h00};
        sh_seq        = '{8'h5B, 8'h7E, 8'hB8, 8'h00, 8'h3D};
        r5_seq        = '{8'hE2, 8'h4F};
        #2;
        chk("rst_data", data_out, 8'h00);
        chk("rst_valid", valid, 1'b0);
        chk("rst_locked", locked, 1'b0);
        chk("rst_offset", offset, 3'd0);

        @(negedge byte_clock);
        reset_n       = 1'b1;
        enable        = 1'b1;
        wait_for_sync = 1'b1;

        // Aligned sync at offset 0
        tick(8'h00);
        tick(8'hB8);
        tick(8'h12);
        chk("al_prelock", locked, 1'b0);
        tick(8'h34);
        chk("al_locked", locked, 1'b1);
        chk("al_offset", offset, 3'd0);
        chk("al_novalid", valid, 1'b0);
        tick(8'h56);
        chk("al_d0_valid", valid, 1'b1);
        chk("al_d0", data_out, 8'h12);
        tick(8'h00);
        chk("al_d1", data_out, 8'h34);
        tick(8'h00);
        chk("al_d2", data_out, 8'h56);
        end_packet();
        chk("al_pd_valid", valid, 1'b0);
        chk("al_pd_locked", locked, 1'b0);
        chk("al_pd_hold", data_out, 8'h56);

        // Search gated off, then enabled before a second sync
        wait_for_sync = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(gate_seq[i]);
            chk("gate_locked", locked, 1'b0);
            chk("gate_valid", valid, 1'b0);
        end
        wait_for_sync = 1'b1;
        tick(8'hB8);
        tick(8'h77);
        tick(8'h88);
        chk("gate2_locked", locked, 1'b1);
        chk("gate2_offset", offset, 3'd0);
        tick(8'h99);
        chk("gate2_valid", valid, 1'b1);
        chk("gate2_data", data_out, 8'h77);
        end_packet();
        chk("gate2_pd_valid", valid, 1'b0);

        // Sync split across bytes at offset 3, payload containing B8
        tick(8'h00);
        tick(8'hC0);
        tick(8'h05);
        tick(8'hA1);
        chk("sh_locked", locked, 1'b1);
        chk("sh_offset", offset, 3'd3);
        for (int i = 0; i < 5; i++) begin
            tick(sh_seq[i]);
            if (i == 0) chk("sh_first_hand", data_out, 8'h20);
            chk("sh_data", data_out, pre_w[10:3]);
            chk("sh_valid", valid, 1'b1);
        end
        chk("sh_offset_kept", offset, 3'd3);
        end_packet();
        chk("sh_pd_valid", valid, 1'b0);
        chk("sh_pd_locked", locked, 1'b0);
        chk("sh_pd_offset", offset, 3'd3);

        // Relock at offset 5
        tick(8'h00);
        tick(8'h17);
        tick(8'h00);
        chk("r5_locked", locked, 1'b1);
        chk("r5_offset", offset, 3'd5);
        for (int i = 0; i < 2; i++) begin
            tick(r5_seq[i]);
            exp_hold = pre_w[12:5];
            chk("r5_data", data_out, exp_hold);
            chk("r5_valid", valid, 1'b1);
        end

        // Enable dropped while locked, sync present in the window
        enable = 1'b0;
        tick(8'hB8);
        chk("en_valid", valid, 1'b0);
        chk("en_locked", locked, 1'b0);
        tick(8'h00);
        chk("en_locked2", locked, 1'b0);
        tick(8'h00);
        chk("en_locked3", locked, 1'b0);
        chk("en_valid3", valid, 1'b0);
        chk("en_offset_hold", offset, 3'd5);
        chk("en_data_hold", data_out, exp_hold);
        enable = 1'b1;
        tick(8'hB8);
        tick(8'h3C);
        tick(8'h00);
        chk("en_relock", locked, 1'b1);
        chk("en_reoffset", offset, 3'd0);
        tick(8'h00);
        chk("en_redata", data_out, 8'h3C);
        chk("en_revalid", valid, 1'b1);

        // Asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        h0 = 8'h00;
        h1 = 8'h00;
        #1;
        chk("ar_data", data_out, 8'h00);
        chk("ar_valid", valid, 1'b0);
        chk("ar_locked", locked, 1'b0);
        chk("ar_offset", offset, 3'd0);
        #1;
        reset_n = 1'b1;
        tick(8'h00);
        tick(8'hB8);
        tick(8'h44);
        tick(8'h00);
        chk("ar_relock", locked, 1'b1);
        tick(8'h00);
        chk("ar_redata", data_out, 8'h44);
        chk("ar_revalid", valid, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/csi_rx_byte_align.md
# csi_rx_byte_align

Per-lane byte aligner for the CSI-2 receiver, clocked by the recovered `byte_clock` and fed directly by the lane's 8-bit ISERDES output. While that ISERDES is held in reset by the byte-clock detector, `enable` is low. The aligner hunts for the HS sync byte at any of 8 bit offsets across two consecutive deserialized bytes, then locks that offset. It emits realigned payload bytes with a valid strobe until the packet layer signals end of packet.

## Interface
- `SYNC_BYTE`, default 8'hB8: HS leader/sync byte, LSB-first bit order.
- `byte_clock` in 1: lane byte clock; sole clock of the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `enable` in 1: active1; low whenever the upstream ISERDES is in reset (driven from the inverted clock-detector `reset_out`).
- `deser_in` in 8: raw ISERDES byte; bit 0 is the earliest received bit.
- `wait_for_sync` in 1: active1; permits sync search while hunting.
- `packet_done` in 1: active1 single-cycle pulse from the packet handler; ends the current packet.
- `data_out` out 8: aligned byte.
- `valid` out 1: `data_out` carries a payload byte.
- `locked` out 1: aligner is in LOCKED state.
- `offset` out 3: bit offset latched at lock.

## Operation
- Shift pipe, every edge regardless of state or `enable`: `d0 <= deser_in; d1 <= d0`.
- Window `w[15:0] = {d0, d1}`, with `d1` the older byte. Candidate k (0..7) = `w[k+7:k]`.
- `match` = any candidate equals `SYNC_BYTE`. `k_hit` = lowest matching k (priority to k=0).
- FSM states: HUNT (reset state) and LOCKED.
- HUNT -> LOCKED on an edge where `enable & wait_for_sync & match`. Same edge: `offset <= k_hit`, `locked <= 1`.
- In HUNT: `valid <= 0` and `packet_done` is ignored. With `wait_for_sync=0`, no search and no transition.
- In LOCKED, each edge: `data_out <= w[offset+7:offset]` and `valid <= 1`. `offset` is frozen.
- LOCKED -> HUNT on an edge with `packet_done=1`. That edge: `valid <= 0`, `locked <= 0`, no `data_out` update.
- `enable=0` overrides everything. On any edge with `enable=0`: state to HUNT, `valid <= 0`, `locked <= 0`. `offset` and `data_out` hold.
- No re-search while LOCKED. A `SYNC_BYTE` inside payload is passed through as data.
- `data_out` holds its last value whenever `valid=0`; consumers qualify it with `valid` only.
- Multiple simultaneous matches: lowest k wins. Example: 8'hB8 appearing at both k=0 and another k selects 0.

## Timing
- Reset (`reset_n=0`, asynchronous): `d0=d1=0`, state HUNT, `data_out=8'h00`, `valid=0`, `locked=0`, `offset=3'd0`. Deassertion is taken synchronously by the integrating level.
- Match detect: the sync byte is fully in the window after edge E. `locked=1` and `offset` are valid after edge E+1.
- First valid: after edge E+2, `data_out` = byte immediately following the sync byte, `valid=1`. No payload byte is lost or duplicated.
- Steady-state latency: a byte sampled from `deser_in` at edge n (offset 0) appears on `data_out` after edge n+2. For nonzero offset, the byte is complete once its last bits are in `d0`. Latency is the same 2 edges from that edge.
- `packet_done` at edge P: `valid=0` after P. A match in the window at P+1 can lock again at P+1 if `wait_for_sync=1`.
- `reset_n` asserted mid-packet: all outputs go to reset values immediately, with no clock required.

## Test plan
- Aligned sync: `deser_in` = 00, B8, 12, 34, 56 on consecutive edges, `wait_for_sync=1` -> `offset=0`; `data_out` = 12, 34, 56 with `valid=1` from the 5th edge on.
- Shifted sync: `deser_in` = 00, C0, 05, then payload -> lock with `offset=3`. Output bytes equal bits [10:3] of each following window; the bench compares against a bit-level model.
- Gating: same stream as the aligned test with `wait_for_sync=0` -> `locked` stays 0, `valid` stays 0. Raise `wait_for_sync` before a second B8 -> locks on the second B8 only.
- Packet end: lock, stream 4 bytes, pulse `packet_done` -> `valid` falls on that edge. B8 inside the payload before `packet_done` does not change `offset`. A new B8 afterwards relocks, including at a different offset (e.g. 5).
- Enable drop: while LOCKED, hold `enable=0` for 3 edges with B8 present -> `valid=0`, `locked=0`, no lock. Re-enable -> next B8 locks.
- Async reset mid-packet: pulse `reset_n` low between edges -> all outputs 0 immediately. Recovery locks normally on the next sync.
